// File: rtl/slc3_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : slc3_fetch_unit
// Brief    : SLC-3 instruction fetch engine (PC/MAR/MDR/IR) with wait states,
//            valid/ready issue handshake, branch redirect and pause opcode.
// Revision : 1.0
// ============================================================================
module slc3_fetch_unit #(
  parameter int                    DATA_WIDTH   = 16,
  parameter int                    MEM_WAIT     = 1,
  parameter logic [DATA_WIDTH-1:0] RESET_PC     = '0,
  parameter logic [3:0]            PAUSE_OPCODE = 4'hD
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run_i,
  input  logic                  continue_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic                  mem_mem_ena,
  output logic                  mem_wr_ena,
  output logic [DATA_WIDTH-1:0] ir_o,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic                  ir_valid_o,
  input  logic                  ir_ready_i,
  input  logic                  redirect_i,
  input  logic [DATA_WIDTH-1:0] redirect_pc_i,
  output logic                  halted_o,
  output logic                  paused_o
);

  localparam int c_cnt_w = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;

  localparam logic [c_cnt_w-1:0]    c_cnt_init = c_cnt_w'(MEM_WAIT - 1);
  localparam logic [c_cnt_w-1:0]    c_cnt_one  = {{(c_cnt_w-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0] c_pc_one   = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

  localparam logic [2:0] c_st_halted     = 3'd0;
  localparam logic [2:0] c_st_fetch_addr = 3'd1;
  localparam logic [2:0] c_st_fetch_wait = 3'd2;
  localparam logic [2:0] c_st_load_ir    = 3'd3;
  localparam logic [2:0] c_st_issue      = 3'd4;
  localparam logic [2:0] c_st_paused     = 3'd5;

  logic [2:0]            r_state;
  logic [DATA_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] r_mar;
  logic [DATA_WIDTH-1:0] r_mdr;
  logic [DATA_WIDTH-1:0] r_ir;
  logic [c_cnt_w-1:0]    r_cnt;
  logic                  r_cont_q;
  logic                  w_is_pause;

  assign w_is_pause = (r_ir[DATA_WIDTH-1 -: 4] == PAUSE_OPCODE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= c_st_halted;
      r_pc     <= RESET_PC;
      r_mar    <= '0;
      r_mdr    <= '0;
      r_ir     <= '0;
      r_cnt    <= '0;
      r_cont_q <= 1'b0;
    end else begin
      r_cont_q <= continue_i;
      case (r_state)
        c_st_halted: begin
          if (redirect_i) r_pc <= redirect_pc_i;
          if (run_i) r_state <= c_st_fetch_addr;
        end
        c_st_fetch_addr: begin
          if (redirect_i) begin
            r_pc <= redirect_pc_i;
          end else begin
            r_mar   <= r_pc;
            r_pc    <= r_pc + c_pc_one;
            r_cnt   <= c_cnt_init;
            r_state <= c_st_fetch_wait;
          end
        end
        c_st_fetch_wait: begin
          // A redirect drops the in-flight read before it can reach MDR.
          if (redirect_i) begin
            r_pc    <= redirect_pc_i;
            r_state <= c_st_fetch_addr;
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - c_cnt_one;
          end else begin
            r_mdr   <= mem_rdata;
            r_state <= c_st_load_ir;
          end
        end
        c_st_load_ir: begin
          if (redirect_i) begin
            r_pc    <= redirect_pc_i;
            r_state <= c_st_fetch_addr;
          end else begin
            r_ir    <= r_mdr;
            r_state <= c_st_issue;
          end
        end
        c_st_issue: begin
          // A handshake in the same cycle as a redirect still delivers the IR.
          if (ir_ready_i) begin
            r_state <= w_is_pause ? c_st_paused : c_st_fetch_addr;
          end else if (redirect_i) begin
            r_state <= c_st_fetch_addr;
          end
          if (redirect_i) r_pc <= redirect_pc_i;
        end
        c_st_paused: begin
          if (redirect_i) r_pc <= redirect_pc_i;
          if (continue_i && !r_cont_q) r_state <= c_st_fetch_addr;
        end
        default: r_state <= c_st_halted;
      endcase
    end
  end

  assign mem_addr    = r_mar;
  assign mem_mem_ena = (r_state == c_st_fetch_wait);
  assign mem_wr_ena  = 1'b0;
  assign ir_o        = r_ir;
  assign pc_o        = r_pc;
  assign ir_valid_o  = (r_state == c_st_issue);
  assign halted_o    = (r_state == c_st_halted);
  assign paused_o    = (r_state == c_st_paused);

endmodule
`default_nettype wire
